// File: rtl/mp3_pkg.sv
// Shared constants and reader state type for the subband-to-MDCT granule buffer.
package mp3_pkg;

    localparam int SUBBANDS      = 32;
    localparam int SLOTS         = 18;
    localparam int WIDTH         = 32;
    localparam int MDCT_LEN      = 36;
    localparam int GRANULE_WORDS = 576;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_READ  = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_t;

    function automatic logic [1:0] bank_next(input logic [1:0] b);
        return (b == 2'd2) ? 2'd0 : b + 2'd1;
    endfunction

    function automatic logic [1:0] bank_prev(input logic [1:0] b);
        return (b == 2'd0) ? 2'd2 : b - 2'd1;
    endfunction

endpackage

// File: rtl/granule_ram.sv
// Simple dual-port storage for the three granule banks; one-cycle registered read.
module granule_ram #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 1728,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/subband_granule_buffer.sv
// Collects filterbank slots into rotating granule banks and streams 36-sample,
// frequency-inverted MDCT windows (previous granule half, then current half).
//
// state    | meaning
// RD_IDLE  | waiting for a completed granule
// RD_READ  | issuing read addresses, sb 0..31 outer, n 0..35 inner
// RD_DRAIN | all addresses issued, waiting for the last word to be accepted
module subband_granule_buffer #(
    parameter int SUBBANDS = mp3_pkg::SUBBANDS,
    parameter int SLOTS    = mp3_pkg::SLOTS,
    parameter int WIDTH    = mp3_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] subband_sample,
    input  logic             subband_sample_valid,
    output logic [WIDTH-1:0] mdct_sample,
    output logic             mdct_valid,
    input  logic             mdct_ready,
    output logic [4:0]       mdct_subband,
    output logic [5:0]       mdct_idx,
    output logic             mdct_last,
    output logic             overflow
);

    import mp3_pkg::MDCT_LEN;
    import mp3_pkg::rd_state_t;
    import mp3_pkg::RD_IDLE;
    import mp3_pkg::RD_READ;
    import mp3_pkg::RD_DRAIN;
    import mp3_pkg::bank_next;
    import mp3_pkg::bank_prev;

    localparam int GRAN   = SLOTS * SUBBANDS;
    localparam int DEPTH  = 3 * GRAN;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [4:0] SB_LAST   = 5'(SUBBANDS - 1);
    localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);
    localparam logic [5:0] N_LAST    = 6'(MDCT_LEN - 1);
    localparam logic [5:0] N_HALF    = 6'(MDCT_LEN / 2);
    localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    function automatic logic [ADDR_W-1:0] addr_of(input logic [1:0] bank,
                                                  input logic [4:0] slot,
                                                  input logic [4:0] sb);
        return ADDR_W'(int'(bank) * GRAN + int'(slot) * SUBBANDS + int'(sb));
    endfunction

    logic [1:0] wbank;
    logic [4:0] wslot, wsb;
    logic       wr_end, gran_done;

    assign wr_end = subband_sample_valid && (wslot == SLOT_LAST) && (wsb == SB_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbank     <= '0;
            wslot     <= '0;
            wsb       <= '0;
            gran_done <= 1'b0;
        end else begin
            gran_done <= wr_end;
            if (subband_sample_valid) begin
                if (wsb == SB_LAST) begin
                    wsb <= '0;
                    if (wslot == SLOT_LAST) begin
                        wslot <= '0;
                        wbank <= bank_next(wbank);
                    end else begin
                        wslot <= wslot + 5'd1;
                    end
                end else begin
                    wsb <= wsb + 5'd1;
                end
            end
        end
    end

    rd_state_t         state, state_nx;
    logic [4:0]        rsb;
    logic [5:0]        rn;
    logic [1:0]        rd_old, rd_mid, cur_old, cur_mid;
    logic              rd_zero, cur_zero, primed;
    logic              start, issue, issue_zero, advance, re;
    logic [ADDR_W-1:0] raddr;
    logic [WIDTH-1:0]  rdata, shaped;
    logic              s1_valid, s1_zero, s1_neg, s1_last;
    logic [4:0]        s1_sb;
    logic [5:0]        s1_n;

    // The first word is issued in the gran_done cycle itself, so the bank
    // selection and priming decision bypass their capture registers there.
    assign start    = gran_done && (state == RD_IDLE);
    assign advance  = !mdct_valid || mdct_ready;
    assign cur_old  = start ? bank_next(wbank) : rd_old;
    assign cur_mid  = start ? bank_prev(wbank) : rd_mid;
    assign cur_zero = start ? !primed : rd_zero;
    assign issue_zero = cur_zero && (rn < N_HALF);
    assign re = issue && !issue_zero;

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        unique case (state)
            RD_IDLE: begin
                if (start) begin
                    state_nx = RD_READ;
                    issue    = advance;
                end
            end
            RD_READ: begin
                issue = advance;
                if (advance && (rsb == SB_LAST) && (rn == N_LAST)) state_nx = RD_DRAIN;
            end
            RD_DRAIN: begin
                if (mdct_valid && mdct_ready && mdct_last) state_nx = RD_IDLE;
            end
            default: state_nx = RD_IDLE;
        endcase
    end

    always_comb begin
        raddr = '0;
        if (rn < N_HALF) raddr = addr_of(cur_old, rn[4:0], rsb);
        else             raddr = addr_of(cur_mid, 5'(rn - N_HALF), rsb);
    end

    always_comb begin
        shaped = rdata;
        if (s1_zero)     shaped = '0;
        else if (s1_neg) shaped = (rdata == S_MIN) ? S_MAX : ('0 - rdata);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RD_IDLE;
            rsb          <= '0;
            rn           <= '0;
            rd_old       <= '0;
            rd_mid       <= '0;
            rd_zero      <= 1'b1;
            primed       <= 1'b0;
            overflow     <= 1'b0;
            s1_valid     <= 1'b0;
            s1_zero      <= 1'b0;
            s1_neg       <= 1'b0;
            s1_last      <= 1'b0;
            s1_sb        <= '0;
            s1_n         <= '0;
            mdct_valid   <= 1'b0;
            mdct_last    <= 1'b0;
            mdct_sample  <= '0;
            mdct_subband <= '0;
            mdct_idx     <= '0;
        end else begin
            state <= state_nx;
            if (gran_done) primed <= 1'b1;
            if (gran_done && (state != RD_IDLE)) overflow <= 1'b1;
            if (start) begin
                rd_old  <= cur_old;
                rd_mid  <= cur_mid;
                rd_zero <= cur_zero;
            end
            if (issue) begin
                if (rn == N_LAST) begin
                    rn  <= '0;
                    rsb <= rsb + 5'd1;
                end else begin
                    rn <= rn + 6'd1;
                end
            end
            if (advance) begin
                s1_valid     <= issue;
                s1_zero      <= issue_zero;
                // n mod 18 has the parity of n because 18 is even
                s1_neg       <= rsb[0] && rn[0];
                s1_last      <= (rsb == SB_LAST) && (rn == N_LAST);
                s1_sb        <= rsb;
                s1_n         <= rn;
                mdct_valid   <= s1_valid;
                mdct_last    <= s1_valid && s1_last;
                mdct_sample  <= shaped;
                mdct_subband <= s1_sb;
                mdct_idx     <= s1_n;
            end
        end
    end

    granule_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (subband_sample_valid),
        .waddr (addr_of(wbank, wslot, wsb)),
        .wdata (subband_sample),
        .re    (re),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule
